// File: rtl/cpu_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, mstatus
// bit positions, interrupt bit indices / cause codes and the write-op encoding.
package cpu_csr_pkg;

    localparam int unsigned CNT_W = 64;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP  = 11;   // MPP occupies [12:11]

    // Interrupt bit indices in mip/mie, equal to the mcause interrupt codes
    localparam int unsigned IRQ_MSI       = 3;
    localparam int unsigned IRQ_MTI       = 7;
    localparam int unsigned IRQ_MEI       = 11;
    localparam int unsigned IRQ_LIRQ_BASE = 16;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        WOP_NONE  = 2'b00,
        WOP_WRITE = 2'b01,
        WOP_SET   = 2'b10,
        WOP_CLEAR = 2'b11
    } wop_e;

endpackage

// File: rtl/cpu_csr_counter.sv
// 64-bit event counter with inhibit, increment strobe and half-word writes.
// Ports: clk/rst, inhibit, inc, wr_lo (writes [XLEN-1:0]), wr_hi (writes
// [63:32], only meaningful when XLEN=32), wdata, rd_lo/rd_hi readout.
module cpu_csr_counter
    import cpu_csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inhibit,
    input  logic            inc,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rd_lo,
    output logic [31:0]     rd_hi
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A software write to either half takes precedence over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[XLEN-1:0] = wdata;
            if (wr_hi) cnt_d[63:32]    = wdata[31:0];
        end else if (inc && !inhibit) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign rd_lo = cnt_q[XLEN-1:0];
    assign rd_hi = cnt_q[63:32];

endmodule

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR unit: CSR read/write/set/clear with illegal-access
// detection, trap/interrupt/mret state updates, trap vector generation and
// mcycle/minstret/HPM counters.
// Ports: raddr->rdata/csr_illegal (combinational), waddr/wdata/wop write port,
// W-stage events (retire_w, exception_w, mret_w), interrupt sources and
// int_req/int_ack handshake, trap_vector, mepc and priv outputs.
module cpu_csr_unit
    import cpu_csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NUM_LIRQ    = 4,
    parameter int unsigned     NUM_HPM     = 2,
    parameter int unsigned     HART_ID     = 0,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         raddr,
    output logic [XLEN-1:0]     rdata,
    output logic                csr_illegal,
    input  logic [11:0]         waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [1:0]          wop,
    input  logic                retire_w,
    input  logic                exception_w,
    input  logic [3:0]          exception_cause_w,
    input  logic [XLEN-1:0]     exception_tval_w,
    input  logic [XLEN-1:0]     pc_w,
    input  logic                mret_w,
    input  logic [XLEN-1:0]     int_pc,
    input  logic                msi_pending,
    input  logic                mti_pending,
    input  logic                mei_pending,
    input  logic [NUM_LIRQ-1:0] lirq_pending,
    input  logic [NUM_HPM-1:0]  hpm_event,
    output logic                int_req,
    input  logic                int_ack,
    output logic [XLEN-1:0]     trap_vector,
    output logic [XLEN-1:0]     mepc,
    output logic [1:0]          priv
);

    localparam int unsigned NCNT = 2 + NUM_HPM;

    // Counter i sits at CSR offset 0 (mcycle), 2 (minstret), 3.. (HPM);
    // the same offset is its mcountinhibit bit.
    function automatic logic [11:0] cnt_off(input int unsigned i);
        return (i == 0) ? 12'd0 : 12'(i + 1);
    endfunction

    function automatic logic [XLEN-1:0] mie_mask_f();
        logic [XLEN-1:0] m;
        m = '0;
        m[IRQ_MSI] = 1'b1;
        m[IRQ_MTI] = 1'b1;
        m[IRQ_MEI] = 1'b1;
        for (int i = 0; i < int'(NUM_LIRQ); i++) m[IRQ_LIRQ_BASE + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] inh_mask_f();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < int'(NCNT); i++) m[cnt_off(i)] = 1'b1;
        return m;
    endfunction

    localparam logic [XLEN-1:0] MIE_MASK = mie_mask_f();
    localparam logic [31:0]     INH_MASK = inh_mask_f();
    localparam logic [XLEN-1:0] MISA_VAL =
        ((XLEN == 64) ? (XLEN'(2) << (XLEN - 2)) : (XLEN'(1) << (XLEN - 2))) | XLEN'(32'h100);

    logic [1:0]      priv_q, priv_d;
    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic [1:0]      mst_mpp_q, mst_mpp_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [31:0]     mcountinhibit_q, mcountinhibit_d;

    logic [XLEN-1:0] cnt_lo [NCNT];
    logic [31:0]     cnt_hi [NCNT];
    logic [NCNT-1:0] cnt_inc, cnt_wr_lo, cnt_wr_hi;

    logic [XLEN:0]   rd_r, rd_w;
    logic            we;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] irq_pend;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] trap_base;

    // Read mux; MSB of the result flags an implemented address.
    function automatic logic [XLEN:0] csr_rd(input logic [11:0] a);
        logic [XLEN:0]   r;
        logic [XLEN-1:0] mst;
        mst = '0;
        mst[MSTATUS_MIE]                 = mst_mie_q;
        mst[MSTATUS_MPIE]                = mst_mpie_q;
        mst[MSTATUS_MPP+1:MSTATUS_MPP]   = mst_mpp_q;
        r = {1'b1, XLEN'(0)};
        case (a)
            CSR_MSTATUS:       r[XLEN-1:0] = mst;
            CSR_MISA:          r[XLEN-1:0] = MISA_VAL;
            CSR_MIE:           r[XLEN-1:0] = mie_q;
            CSR_MTVEC:         r[XLEN-1:0] = mtvec_q;
            CSR_MCOUNTINHIBIT: r[XLEN-1:0] = XLEN'(mcountinhibit_q);
            CSR_MSCRATCH:      r[XLEN-1:0] = mscratch_q;
            CSR_MEPC:          r[XLEN-1:0] = mepc_q;
            CSR_MCAUSE:        r[XLEN-1:0] = mcause_q;
            CSR_MTVAL:         r[XLEN-1:0] = mtval_q;
            CSR_MIP:           r[XLEN-1:0] = mip_q;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: r[XLEN-1:0] = '0;
            CSR_MHARTID:       r[XLEN-1:0] = XLEN'(HART_ID);
            default: begin
                r[XLEN] = 1'b0;
                for (int i = 0; i < int'(NCNT); i++) begin
                    if (a == CSR_MCYCLE + cnt_off(i)) r = {1'b1, cnt_lo[i]};
                    // High halves exist only on RV32.
                    if (XLEN == 32 && a == CSR_MCYCLEH + cnt_off(i)) r = {1'b1, XLEN'(cnt_hi[i])};
                end
            end
        endcase
        return r;
    endfunction

    // Access legality, read data and write-value formation.
    always_comb begin
        rd_r        = csr_rd(raddr);
        rd_w        = csr_rd(waddr);
        csr_illegal = !rd_r[XLEN] ||
                      ((wop != WOP_NONE) && (!rd_w[XLEN] || waddr[11:10] == 2'b11));
        rdata       = csr_illegal ? '0 : rd_r[XLEN-1:0];
        we          = (wop != WOP_NONE) && !csr_illegal;
        case (wop_e'(wop))
            WOP_SET:   wval = rd_w[XLEN-1:0] | wdata;
            WOP_CLEAR: wval = rd_w[XLEN-1:0] & ~wdata;
            default:   wval = wdata;
        endcase
    end

    // Interrupt selection: lowest priority assigned first so higher ones override.
    always_comb begin
        irq_pend = mip_q & mie_q;
        irq_code = '0;
        for (int i = int'(NUM_LIRQ) - 1; i >= 0; i--)
            if (irq_pend[IRQ_LIRQ_BASE + i]) irq_code = 5'(IRQ_LIRQ_BASE + i);
        if (irq_pend[IRQ_MTI]) irq_code = 5'(IRQ_MTI);
        if (irq_pend[IRQ_MSI]) irq_code = 5'(IRQ_MSI);
        if (irq_pend[IRQ_MEI]) irq_code = 5'(IRQ_MEI);
        int_req     = mst_mie_q && (|irq_pend) && !int_ack;
        trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
        trap_vector = (!exception_w && mtvec_q[1:0] == 2'b01)
                    ? trap_base + XLEN'({irq_code, 2'b00})
                    : trap_base;
    end

    // Next state: software write, then mret, then trap, so later wins.
    always_comb begin
        priv_d          = priv_q;
        mst_mie_d       = mst_mie_q;
        mst_mpie_d      = mst_mpie_q;
        mst_mpp_d       = mst_mpp_q;
        mie_d           = mie_q;
        mcause_d        = mcause_q;
        mepc_d          = mepc_q;
        mtval_d         = mtval_q;
        mscratch_d      = mscratch_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;

        mip_d                = '0;
        mip_d[IRQ_MSI]       = msi_pending;
        mip_d[IRQ_MTI]       = mti_pending;
        mip_d[IRQ_MEI]       = mei_pending;
        for (int i = 0; i < int'(NUM_LIRQ); i++) mip_d[IRQ_LIRQ_BASE + i] = lirq_pending[i];

        if (we) begin
            case (waddr)
                CSR_MSTATUS: begin
                    mst_mie_d  = wval[MSTATUS_MIE];
                    mst_mpie_d = wval[MSTATUS_MPIE];
                    if (wval[MSTATUS_MPP+1:MSTATUS_MPP] == PRIV_M) mst_mpp_d = PRIV_M;
                end
                CSR_MIE:           mie_d = wval & MIE_MASK;
                CSR_MTVEC:         mtvec_d = {wval[XLEN-1:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wval[31:0] & INH_MASK;
                CSR_MSCRATCH:      mscratch_d = wval;
                CSR_MEPC:          mepc_d = {wval[XLEN-1:2], 2'b00};
                CSR_MCAUSE:        mcause_d = wval;
                CSR_MTVAL:         mtval_d = wval;
                default: ;
            endcase
        end

        if (mret_w) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            priv_d     = mst_mpp_q;
            mst_mpp_d  = PRIV_M;
        end

        if (exception_w || int_ack) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mst_mpp_d  = priv_q;
            priv_d     = PRIV_M;
            if (exception_w) begin
                mepc_d   = {pc_w[XLEN-1:2], 2'b00};
                mcause_d = XLEN'(exception_cause_w);
                mtval_d  = exception_tval_w;
            end else begin
                mepc_d             = {int_pc[XLEN-1:2], 2'b00};
                mcause_d           = XLEN'(irq_code);
                mcause_d[XLEN-1]   = 1'b1;
                mtval_d            = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            priv_q          <= PRIV_M;
            mst_mie_q       <= 1'b0;
            mst_mpie_q      <= 1'b0;
            mst_mpp_q       <= PRIV_M;
            mie_q           <= '0;
            mip_q           <= '0;
            mcause_q        <= '0;
            mepc_q          <= '0;
            mtval_q         <= '0;
            mscratch_q      <= '0;
            mtvec_q         <= RESET_MTVEC;
            mcountinhibit_q <= '0;
        end else begin
            priv_q          <= priv_d;
            mst_mie_q       <= mst_mie_d;
            mst_mpie_q      <= mst_mpie_d;
            mst_mpp_q       <= mst_mpp_d;
            mie_q           <= mie_d;
            mip_q           <= mip_d;
            mcause_q        <= mcause_d;
            mepc_q          <= mepc_d;
            mtval_q         <= mtval_d;
            mscratch_q      <= mscratch_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    for (genvar g = 0; g < int'(NCNT); g++) begin : g_cnt
        if (g == 0) begin : g_cy
            assign cnt_inc[g] = 1'b1;
        end else if (g == 1) begin : g_ir
            assign cnt_inc[g] = retire_w;
        end else begin : g_hpm
            assign cnt_inc[g] = hpm_event[g-2];
        end
        assign cnt_wr_lo[g] = we && (waddr == CSR_MCYCLE + cnt_off(g));
        assign cnt_wr_hi[g] = we && (XLEN == 32) && (waddr == CSR_MCYCLEH + cnt_off(g));

        cpu_csr_counter #(.XLEN(XLEN)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inhibit (mcountinhibit_q[(g == 0) ? 0 : g + 1]),
            .inc     (cnt_inc[g]),
            .wr_lo   (cnt_wr_lo[g]),
            .wr_hi   (cnt_wr_hi[g]),
            .wdata   (wdata),
            .rd_lo   (cnt_lo[g]),
            .rd_hi   (cnt_hi[g])
        );
    end

    assign mepc = mepc_q;
    assign priv = priv_q;

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Directed bench for cpu_csr_unit (RV32 instance plus an RV64 instance for
// XLEN-dependent legality and misa readout).
module tb_cpu_csr_unit;
    import cpu_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata;
    logic        csr_illegal;
    logic [1:0]  wop;
    logic        retire_w, exception_w, mret_w, int_ack, int_req;
    logic [3:0]  exception_cause_w;
    logic [31:0] exception_tval_w, pc_w, int_pc, trap_vector, mepc;
    logic        msi_pending, mti_pending, mei_pending;
    logic [3:0]  lirq_pending;
    logic [1:0]  hpm_event, priv;

    logic [11:0] raddr64;
    logic [63:0] rdata64, trap_vector64, mepc64;
    logic        ill64, int_req64;
    logic [1:0]  priv64;

    int n_chk = 0;
    int n_bad = 0;

    always #50 clk = ~clk;

    cpu_csr_unit #(.XLEN(32), .NUM_LIRQ(4), .NUM_HPM(2), .HART_ID(5), .RESET_MTVEC(32'h100)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .csr_illegal(csr_illegal),
        .waddr(waddr), .wdata(wdata), .wop(wop), .retire_w(retire_w),
        .exception_w(exception_w), .exception_cause_w(exception_cause_w),
        .exception_tval_w(exception_tval_w), .pc_w(pc_w), .mret_w(mret_w), .int_pc(int_pc),
        .msi_pending(msi_pending), .mti_pending(mti_pending), .mei_pending(mei_pending),
        .lirq_pending(lirq_pending), .hpm_event(hpm_event), .int_req(int_req),
        .int_ack(int_ack), .trap_vector(trap_vector), .mepc(mepc), .priv(priv)
    );

    cpu_csr_unit #(.XLEN(64), .NUM_LIRQ(4), .NUM_HPM(2), .HART_ID(1), .RESET_MTVEC(64'h0)) dut64 (
        .clk(clk), .rst(rst), .raddr(raddr64), .rdata(rdata64), .csr_illegal(ill64),
        .waddr(12'h000), .wdata(64'h0), .wop(2'b00), .retire_w(1'b0),
        .exception_w(1'b0), .exception_cause_w(4'h0),
        .exception_tval_w(64'h0), .pc_w(64'h0), .mret_w(1'b0), .int_pc(64'h0),
        .msi_pending(1'b0), .mti_pending(1'b0), .mei_pending(1'b0),
        .lirq_pending(4'h0), .hpm_event(2'b00), .int_req(int_req64),
        .int_ack(1'b0), .trap_vector(trap_vector64), .mepc(mepc64), .priv(priv64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        raddr = CSR_MSTATUS;
        wop   = op;
        waddr = a;
        wdata = d;
        step();
        wop   = WOP_NONE;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, 64'(rdata), 64'(exp));
    endtask

    task automatic do_mret();
        mret_w = 1'b1;
        step();
        mret_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr = CSR_MSTATUS; waddr = '0; wdata = '0; wop = WOP_NONE;
        retire_w = 0; exception_w = 0; exception_cause_w = '0; exception_tval_w = '0;
        pc_w = '0; mret_w = 0; int_pc = '0; int_ack = 0;
        msi_pending = 0; mti_pending = 0; mei_pending = 0; lirq_pending = '0; hpm_event = '0;
        raddr64 = CSR_MSTATUS;
        step(); step();
        rst = 1'b0;
        #1;

        // Reset state
        rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        chk("rst_illegal", 64'(csr_illegal), 64'd0);
        chk("rst_int_req", 64'(int_req), 64'd0);
        chk("rst_priv", 64'(priv), 64'd3);
        rd_chk("rst_mtvec", CSR_MTVEC, 32'h100);
        rd_chk("rst_mhartid", CSR_MHARTID, 32'd5);
        rd_chk("rst_mepc", CSR_MEPC, 32'd0);

        // Write / set / clear
        csr_wr(WOP_WRITE, CSR_MSCRATCH, 32'h0);
        csr_wr(WOP_SET,   CSR_MSCRATCH, 32'hF0);
        csr_wr(WOP_CLEAR, CSR_MSCRATCH, 32'h30);
        rd_chk("mscratch_setclr", CSR_MSCRATCH, 32'hC0);

        // Read-only and unimplemented accesses
        raddr = CSR_MSTATUS; wop = WOP_WRITE; waddr = CSR_MHARTID; wdata = 32'h77;
        #1 chk("wr_mhartid_illegal", 64'(csr_illegal), 64'd1);
        step(); wop = WOP_NONE;
        rd_chk("mhartid_unchanged", CSR_MHARTID, 32'd5);
        raddr = 12'h7C0;
        #1 chk("unimpl_rd_illegal", 64'(csr_illegal), 64'd1);
        chk("unimpl_rd_zero", 64'(rdata), 64'd0);
        wop = WOP_WRITE; waddr = CSR_MSCRATCH; wdata = 32'h55;
        step(); wop = WOP_NONE;
        rd_chk("illegal_no_commit", CSR_MSCRATCH, 32'hC0);

        // WARL fields
        csr_wr(WOP_WRITE, CSR_MTVEC, 32'h1003);
        rd_chk("mtvec_mode_warl", CSR_MTVEC, 32'h1000);
        csr_wr(WOP_WRITE, CSR_MIE, 32'hFFFF_FFFF);
        rd_chk("mie_mask", CSR_MIE, 32'h000F_0888);
        csr_wr(WOP_WRITE, CSR_MEPC, 32'h203);
        rd_chk("mepc_align", CSR_MEPC, 32'h200);

        // Vectored timer interrupt
        csr_wr(WOP_WRITE, CSR_MTVEC, 32'h1001);
        csr_wr(WOP_WRITE, CSR_MIE, 32'h80);
        csr_wr(WOP_WRITE, CSR_MSTATUS, 32'h8);
        rd_chk("mstatus_mie_set", CSR_MSTATUS, 32'h1808);
        mti_pending = 1'b1;
        #1 chk("int_req_t0", 64'(int_req), 64'd0);
        step();
        chk("int_req_t1", 64'(int_req), 64'd1);
        int_ack = 1'b1; int_pc = 32'h200;
        #1 chk("tvec_vectored", 64'(trap_vector), 64'h101C);
        chk("int_req_ack_forced", 64'(int_req), 64'd0);
        step();
        int_ack = 1'b0; mti_pending = 1'b0;
        rd_chk("int_mcause", CSR_MCAUSE, 32'h8000_0007);
        rd_chk("int_mepc", CSR_MEPC, 32'h200);
        rd_chk("int_mstatus", CSR_MSTATUS, 32'h1880);
        do_mret();
        rd_chk("mret1_mstatus", CSR_MSTATUS, 32'h1888);

        // Exception and interrupt ack together, plus a conflicting mepc write
        raddr = CSR_MSTATUS;
        exception_w = 1'b1; exception_cause_w = 4'd2; exception_tval_w = 32'hDEAD;
        pc_w = 32'h344; int_ack = 1'b1; int_pc = 32'h500;
        wop = WOP_WRITE; waddr = CSR_MEPC; wdata = 32'h999;
        #1 chk("tvec_exception", 64'(trap_vector), 64'h1000);
        step();
        exception_w = 1'b0; int_ack = 1'b0; wop = WOP_NONE;
        rd_chk("exc_mcause", CSR_MCAUSE, 32'h2);
        rd_chk("exc_mtval", CSR_MTVAL, 32'hDEAD);
        rd_chk("exc_mepc", CSR_MEPC, 32'h344);
        rd_chk("exc_mstatus", CSR_MSTATUS, 32'h1880);
        do_mret();
        rd_chk("mret2_mstatus", CSR_MSTATUS, 32'h1888);
        chk("mret2_priv", 64'(priv), 64'd3);

        // Priority: MEI over lirq[0], then lirq[0] alone
        csr_wr(WOP_WRITE, CSR_MIE, 32'h0001_0800);
        mei_pending = 1'b1; lirq_pending = 4'b0001;
        step();
        chk("prio_int_req", 64'(int_req), 64'd1);
        int_ack = 1'b1; int_pc = 32'h300;
        #1 chk("prio_tvec_mei", 64'(trap_vector), 64'h102C);
        step();
        int_ack = 1'b0; mei_pending = 1'b0;
        rd_chk("prio_mcause_mei", CSR_MCAUSE, 32'h8000_000B);
        do_mret();
        chk("lirq_int_req", 64'(int_req), 64'd1);
        int_ack = 1'b1;
        #1 chk("lirq_tvec", 64'(trap_vector), 64'h1040);
        step();
        int_ack = 1'b0; lirq_pending = '0;
        rd_chk("lirq_mcause", CSR_MCAUSE, 32'h8000_0010);
        do_mret();

        // minstret counting, inhibit and write-on-retire
        retire_w = 1'b1;
        repeat (3) step();
        retire_w = 1'b0;
        rd_chk("minstret_cnt", CSR_MINSTRET, 32'd3);
        csr_wr(WOP_WRITE, CSR_MCOUNTINHIBIT, 32'h4);
        retire_w = 1'b1;
        repeat (5) step();
        retire_w = 1'b0;
        rd_chk("minstret_inhibit", CSR_MINSTRET, 32'd3);
        csr_wr(WOP_WRITE, CSR_MCOUNTINHIBIT, 32'h0);
        retire_w = 1'b1;
        csr_wr(WOP_WRITE, CSR_MINSTRET, 32'h1234);
        retire_w = 1'b0;
        rd_chk("minstret_wr_retire", CSR_MINSTRET, 32'h1234);
        retire_w = 1'b1;
        step();
        retire_w = 1'b0;
        rd_chk("minstret_after", CSR_MINSTRET, 32'h1235);

        // HPM counter 3 counts its own strobe only
        hpm_event = 2'b01;
        repeat (3) step();
        hpm_event = 2'b00;
        rd_chk("hpm3", CSR_MHPMCOUNTER3, 32'd3);
        rd_chk("hpm4", CSR_MHPMCOUNTER3 + 12'd1, 32'd0);

        // mcycle carry into mcycleh
        csr_wr(WOP_WRITE, CSR_MCYCLEH, 32'h0);
        csr_wr(WOP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_chk("mcycle_wr", CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_chk("mcycleh_wr", CSR_MCYCLEH, 32'h0);
        step(); step();
        rd_chk("mcycleh_carry", CSR_MCYCLEH, 32'h1);
        rd_chk("mcycle_carry", CSR_MCYCLE, 32'h1);

        // RV64 instance
        raddr64 = CSR_MCYCLEH;
        #1 chk("rv64_mcycleh_illegal", 64'(ill64), 64'd1);
        chk("rv64_mcycleh_zero", rdata64, 64'd0);
        raddr64 = CSR_MCYCLE;
        #1 chk("rv64_mcycle_legal", 64'(ill64), 64'd0);
        raddr64 = CSR_MISA;
        #1 chk("rv64_misa", rdata64, 64'h8000_0000_0000_0100);
        rd_chk("rv32_misa", CSR_MISA, 32'h4000_0100);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
